// File: rtl/uart_recv.sv
// 8N1 UART receiver: synchronises the RX line, samples each bit at mid-bit and
// delivers a byte with a one-cycle done strobe, or a one-cycle frame-error strobe.
module uart_recv #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned UART_BPS = 115200
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       uart_rxd_i,
    output logic [7:0] uart_dout_o,
    output logic       uart_done_o,
    output logic       uart_frame_err_o,
    output logic       uart_rx_busy_o
);

    localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int unsigned HALF    = BPS_CNT / 2;
    localparam int unsigned CNT_W   = $clog2(BPS_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q;
    logic             rx_s1_q, rx_s2_q, rx_s3_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       dout_q;
    logic             done_q, err_q, busy_q;

    logic start_edge, mid, wrap;

    assign start_edge = rx_s3_q & ~rx_s2_q;
    // Counter is cleared on the edge cycle, so cycle E+k holds k-1: mid-bit is HALF-1.
    assign mid        = (clk_cnt_q == CNT_MID);
    assign wrap       = (clk_cnt_q == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= uart_rxd_i;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q != StIdle) begin
                if (wrap) begin
                    clk_cnt_q <= '0;
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end else begin
                    clk_cnt_q <= clk_cnt_q + 1'b1;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q   <= StStart;
                        busy_q    <= 1'b1;
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                StStart: begin
                    if (mid && rx_s2_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (wrap) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (mid) begin
                        shift_q <= {rx_s2_q, shift_q[7:1]};
                    end
                    if (wrap && (bit_cnt_q == 4'd8)) begin
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (mid) begin
                        if (rx_s2_q) begin
                            dout_q <= shift_q;
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign uart_dout_o      = dout_q;
    assign uart_done_o      = done_q;
    assign uart_frame_err_o = err_q;
    assign uart_rx_busy_o   = busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv: three instances at different baud settings, each
// driven by a serial frame model; every done/frame_err pulse is checked against a queue.
module tb_uart_recv;

    localparam int BIT_A = 434 * 20;  // 50 MHz / 115200
    localparam int BIT_B = 43 * 20;   // 5 MHz / 115200
    localparam int BIT_C = 520 * 20;  // 5 MHz / 9600

    typedef struct {
        int         inst;
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd  [3];
    logic [7:0] dout [3];
    logic       done [3];
    logic       err  [3];
    logic       busy [3];

    exp_t       sb[$];
    exp_t       mon_e;
    int         vectors = 0;
    int         miscompares = 0;
    int         done_cnt [3] = '{0, 0, 0};
    int         err_cnt  [3] = '{0, 0, 0};
    int         busy_run [3] = '{0, 0, 0};
    int         busy_len [3] = '{0, 0, 0};
    logic       done_p   [3] = '{0, 0, 0};
    logic       err_p    [3] = '{0, 0, 0};
    logic [7:0] last_good[3] = '{8'h00, 8'h00, 8'h00};

    always #10 clk = ~clk;

    uart_recv #(.CLK_FREQ(50000000), .UART_BPS(115200)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .uart_rxd_i(rxd[0]), .uart_dout_o(dout[0]),
        .uart_done_o(done[0]), .uart_frame_err_o(err[0]), .uart_rx_busy_o(busy[0]));
    uart_recv #(.CLK_FREQ(5000000), .UART_BPS(115200)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .uart_rxd_i(rxd[1]), .uart_dout_o(dout[1]),
        .uart_done_o(done[1]), .uart_frame_err_o(err[1]), .uart_rx_busy_o(busy[1]));
    uart_recv #(.CLK_FREQ(5000000), .UART_BPS(9600)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .uart_rxd_i(rxd[2]), .uart_dout_o(dout[2]),
        .uart_done_o(done[2]), .uart_frame_err_o(err[2]), .uart_rx_busy_o(busy[2]));

    // Output monitor: pops the scoreboard on every pulse and tracks busy run lengths.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] || err[i]) begin
                vectors++;
                if (done[i] && err[i]) begin
                    miscompares++;
                    $display("FAIL overlap inst%0d: done=%b err=%b, required not both", i,
                             done[i], err[i]);
                end
                vectors++;
                if ((done[i] && done_p[i]) || (err[i] && err_p[i])) begin
                    miscompares++;
                    $display("FAIL pulse_width inst%0d: pulse high >1 cycle, required 1", i);
                end
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected inst%0d: done=%b err=%b dout=%h, none expected",
                             i, done[i], err[i], dout[i]);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.inst != i || mon_e.err !== err[i] || dout[i] !== mon_e.data) begin
                        miscompares++;
                        $display("FAIL sb inst%0d: got err=%b dout=%h, required inst%0d err=%b dout=%h",
                                 i, err[i], dout[i], mon_e.inst, mon_e.err, mon_e.data);
                    end
                end
            end
            done_cnt[i] += int'(done[i]);
            err_cnt[i]  += int'(err[i]);
            if (busy[i] === 1'b1) begin
                busy_run[i]++;
            end else if (busy_run[i] > 0) begin
                busy_len[i] = busy_run[i];
                busy_run[i] = 0;
            end
            done_p[i] = done[i];
            err_p[i]  = err[i];
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input int inst, input logic is_err, input logic [7:0] d);
        exp_t e;
        e.inst = inst;
        e.err  = is_err;
        e.data = is_err ? last_good[inst] : d;
        if (!is_err) last_good[inst] = d;
        sb.push_back(e);
    endtask

    task automatic send_byte(input int inst, input logic [7:0] d, input logic stop_bit,
                             input int bit_t);
        rxd[inst] = 1'b0;
        #(bit_t);
        for (int k = 0; k < 8; k++) begin
            rxd[inst] = d[k];
            #(bit_t);
        end
        rxd[inst] = stop_bit;
        #(bit_t);
        rxd[inst] = 1'b1;
    endtask

    task automatic wait_sb(input int max_cyc, output bit ok);
        for (int k = 0; k < max_cyc && sb.size() != 0; k++) @(negedge clk);
        ok = (sb.size() == 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) rxd[i] = 1'b1;
        #15;
        for (int i = 0; i < 3; i++) begin
            vectors += 4;
            if (dout[i] !== 8'h00) begin
                miscompares++; $display("FAIL reset_dout inst%0d: got %h want 00", i, dout[i]);
            end
            if (done[i] !== 1'b0) begin
                miscompares++; $display("FAIL reset_done inst%0d: got %b want 0", i, done[i]);
            end
            if (err[i] !== 1'b0) begin
                miscompares++; $display("FAIL reset_err inst%0d: got %b want 0", i, err[i]);
            end
            if (busy[i] !== 1'b0) begin
                miscompares++; $display("FAIL reset_busy inst%0d: got %b want 0", i, busy[i]);
            end
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int d0 = done_cnt[0];
        int e0 = err_cnt[0];
        bit ok;
        @(posedge clk); #3;
        push(0, 1'b0, 8'h48);
        send_byte(0, 8'h48, 1'b1, BIT_A);
        wait_sb(2000, ok);
        vectors += 5;
        if (!ok) begin
            miscompares++; $display("FAIL single_timeout: %0d entries left, want 0", sb.size());
        end
        if (done_cnt[0] - d0 != 1) begin
            miscompares++; $display("FAIL single_done: got %0d pulses want 1", done_cnt[0] - d0);
        end
        if (err_cnt[0] != e0) begin
            miscompares++; $display("FAIL single_err: got %0d pulses want 0", err_cnt[0] - e0);
        end
        if (busy_len[0] != 9 * 434 + 217) begin
            miscompares++; $display("FAIL single_busy: got %0d cycles want %0d", busy_len[0],
                                    9 * 434 + 217);
        end
        if (dout[0] !== 8'h48) begin
            miscompares++; $display("FAIL single_dout: got %h want 48", dout[0]);
        end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt[0];
        int e0 = err_cnt[0];
        logic [7:0] prev = last_good[0];
        @(posedge clk); #3;
        rxd[0] = 1'b0;
        repeat (100) @(posedge clk);
        #3 rxd[0] = 1'b1;
        repeat (400) @(negedge clk);
        vectors += 3;
        if (busy_len[0] != 217) begin
            miscompares++; $display("FAIL glitch_busy: got %0d cycles want 217", busy_len[0]);
        end
        if (done_cnt[0] != d0 || err_cnt[0] != e0) begin
            miscompares++; $display("FAIL glitch_pulse: got done %0d err %0d want 0 0",
                                    done_cnt[0] - d0, err_cnt[0] - e0);
        end
        if (dout[0] !== prev) begin
            miscompares++; $display("FAIL glitch_dout: got %h want %h", dout[0], prev);
        end
    endtask

    task automatic test_frame_err();
        int d0 = done_cnt[0];
        int e0 = err_cnt[0];
        bit ok;
        @(posedge clk); #3;
        push(0, 1'b0, 8'h48);
        send_byte(0, 8'h48, 1'b1, BIT_A);
        push(0, 1'b1, 8'hA5);
        send_byte(0, 8'hA5, 1'b0, BIT_A);
        #(2 * BIT_A);
        push(0, 1'b0, 8'h5A);
        send_byte(0, 8'h5A, 1'b1, BIT_A);
        wait_sb(2000, ok);
        vectors += 4;
        if (!ok) begin
            miscompares++; $display("FAIL ferr_timeout: %0d entries left, want 0", sb.size());
        end
        if (done_cnt[0] - d0 != 2) begin
            miscompares++; $display("FAIL ferr_done: got %0d pulses want 2", done_cnt[0] - d0);
        end
        if (err_cnt[0] - e0 != 1) begin
            miscompares++; $display("FAIL ferr_err: got %0d pulses want 1", err_cnt[0] - e0);
        end
        if (dout[0] !== 8'h5A) begin
            miscompares++; $display("FAIL ferr_dout: got %h want 5a", dout[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                                 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
        int d0 = done_cnt[1];
        int e0 = err_cnt[1];
        bit ok;
        @(posedge clk); #3;
        for (int k = 0; k < 12; k++) begin
            push(1, 1'b0, msg[k]);
            send_byte(1, msg[k], 1'b1, BIT_B);
        end
        wait_sb(2000, ok);
        vectors += 4;
        if (!ok) begin
            miscompares++; $display("FAIL b2b_timeout: %0d entries left, want 0", sb.size());
        end
        if (done_cnt[1] - d0 != 12) begin
            miscompares++; $display("FAIL b2b_done: got %0d pulses want 12", done_cnt[1] - d0);
        end
        if (err_cnt[1] != e0) begin
            miscompares++; $display("FAIL b2b_err: got %0d pulses want 0", err_cnt[1] - e0);
        end
        if (dout[1] !== 8'h21) begin
            miscompares++; $display("FAIL b2b_dout: got %h want 21", dout[1]);
        end
    endtask

    task automatic test_reset_midframe();
        int d0, e0;
        bit ok;
        @(posedge clk); #3;
        fork
            send_byte(0, 8'hFF, 1'b1, BIT_A);
            begin
                #(4 * BIT_A + BIT_A / 2);
                rst_n = 1'b0;
                #1;
                vectors += 3;
                if (dout[0] !== 8'h00) begin
                    miscompares++; $display("FAIL rstmid_dout: got %h want 00", dout[0]);
                end
                if (busy[0] !== 1'b0) begin
                    miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy[0]);
                end
                if (done[0] !== 1'b0 || err[0] !== 1'b0) begin
                    miscompares++; $display("FAIL rstmid_pulse: got done=%b err=%b want 0 0",
                                            done[0], err[0]);
                end
                for (int i = 0; i < 3; i++) last_good[i] = 8'h00;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        d0 = done_cnt[0];
        e0 = err_cnt[0];
        repeat (20) @(negedge clk);
        #3;
        push(0, 1'b0, 8'h3C);
        send_byte(0, 8'h3C, 1'b1, BIT_A);
        wait_sb(2000, ok);
        vectors += 3;
        if (!ok) begin
            miscompares++; $display("FAIL rstmid_timeout: %0d entries left, want 0", sb.size());
        end
        if (done_cnt[0] - d0 != 1 || err_cnt[0] != e0) begin
            miscompares++; $display("FAIL rstmid_count: got done %0d err %0d want 1 0",
                                    done_cnt[0] - d0, err_cnt[0] - e0);
        end
        if (dout[0] !== 8'h3C) begin
            miscompares++; $display("FAIL rstmid_next: got %h want 3c", dout[0]);
        end
    endtask

    task automatic test_skew();
        int d0 = done_cnt[2];
        int e0 = err_cnt[2];
        bit ok;
        @(posedge clk); #3;
        push(2, 1'b0, 8'h00);
        send_byte(2, 8'h00, 1'b1, BIT_C * 102 / 100);
        #(BIT_C);
        push(2, 1'b0, 8'hFF);
        send_byte(2, 8'hFF, 1'b1, BIT_C * 98 / 100);
        wait_sb(2000, ok);
        vectors += 3;
        if (!ok) begin
            miscompares++; $display("FAIL skew_timeout: %0d entries left, want 0", sb.size());
        end
        if (done_cnt[2] - d0 != 2 || err_cnt[2] != e0) begin
            miscompares++; $display("FAIL skew_count: got done %0d err %0d want 2 0",
                                    done_cnt[2] - d0, err_cnt[2] - e0);
        end
        if (dout[2] !== 8'hFF) begin
            miscompares++; $display("FAIL skew_dout: got %h want ff", dout[2]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        test_skew();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
